// File: rtl/ov7670_pkg.sv
// Shared constants and FSM encoding for the OV7670 SCCB configuration controller.
package ov7670_pkg;

  localparam logic [7:0]  SCCB_ID    = 8'h42;
  localparam logic [7:0]  REG_COM7   = 8'h12;
  localparam logic [7:0]  REG_COM15  = 8'h40;
  localparam logic [7:0]  REG_RGB444 = 8'h8C;
  localparam logic [7:0]  REG_CLKRC  = 8'h11;
  localparam logic [15:0] ROM_END    = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_WAIT,
    S_NEXT
  } cfg_state_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// Register/value table for QVGA capture; rgbmode picks RGB444 or YUV422 values.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int unsigned c_nb_rom_addr = 6
) (
  input  logic [c_nb_rom_addr-1:0] idx,
  input  logic                     rgbmode,
  output logic [15:0]              data
);

  always_comb begin
    data = ROM_END;
    case (int'(idx))
      0: data = {REG_COM7, 8'h80};                          // soft reset, followed by a settle wait
      1: data = {REG_CLKRC, 8'h01};
      2: data = {REG_COM7, rgbmode ? 8'h14 : 8'h10};
      3: data = {8'h0C, 8'h04};
      4: data = {8'h3E, 8'h19};
      5: data = {REG_COM15, rgbmode ? 8'hD0 : 8'hC0};
      6: data = {REG_RGB444, rgbmode ? 8'h02 : 8'h00};
      7: data = {8'h3A, 8'h04};
      default: data = ROM_END;
    endcase
  end

endmodule

// File: rtl/ov7670_config.sv
// OV7670 power-up configuration: walks the register ROM and writes each entry
// as a 3-phase SCCB transaction; raises done when the end marker is reached.
module ov7670_config
  import ov7670_pkg::*;
#(
  parameter int unsigned c_clk_freq    = 100_000_000,
  parameter int unsigned c_sccb_freq   = 100_000,
  parameter int unsigned c_quarter     = c_clk_freq / (4 * c_sccb_freq),
  parameter logic [7:0]  c_dev_addr    = SCCB_ID,
  parameter int unsigned c_rst_wait    = 1_000_000,
  parameter int unsigned c_nb_rom_addr = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     rgbmode,
  output logic                     sioc,
  output logic                     siod_out,
  output logic                     siod_oe,
  output logic                     busy,
  output logic                     done,
  output logic [c_nb_rom_addr-1:0] reg_idx
);

  localparam logic [15:0]              q_last   = 16'(c_quarter - 1);
  localparam logic [31:0]              w_last   = 32'(c_rst_wait - 1);
  localparam logic [c_nb_rom_addr-1:0] idx_last = '1;

  cfg_state_t  state;
  logic [15:0] qcnt;
  logic [1:0]  phase;
  logic [4:0]  bit_cnt;
  logic [26:0] shreg;
  logic [31:0] wcnt;
  logic        rst_entry;
  logic        rgb_q;
  logic        auto_go;
  logic [15:0] rom_data;
  logic        bus_active;
  logic        tick;

  assign bus_active = (state == S_START) || (state == S_BITS) ||
                      (state == S_STOP)  || (state == S_GAP);
  assign tick       = bus_active && (qcnt == q_last);

  ov7670_reg_rom #(.c_nb_rom_addr(c_nb_rom_addr)) u_rom (
    .idx     (reg_idx),
    .rgbmode (rgb_q),
    .data    (rom_data)
  );

  // start is a one-clock request accepted only in IDLE; busy covers the whole table walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sioc      <= 1'b1;
      siod_out  <= 1'b1;
      siod_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_idx   <= '0;
      qcnt      <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
      wcnt      <= '0;
      rst_entry <= 1'b0;
      rgb_q     <= 1'b0;
      auto_go   <= 1'b1;
    end else begin
      // Quarter-period counter only runs while the bus is being sequenced
      if (!bus_active || tick) qcnt <= '0;
      else                     qcnt <= qcnt + 16'd1;
      if (tick) phase <= phase + 2'd1;

      case (state)
        S_IDLE: begin
          if (start || auto_go) begin
            auto_go <= 1'b0;
            rgb_q   <= rgbmode;
            busy    <= 1'b1;
            done    <= 1'b0;
            reg_idx <= '0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_data == ROM_END || reg_idx == idx_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            shreg     <= {c_dev_addr, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
            rst_entry <= (rom_data[15:8] == REG_COM7) && rom_data[7];
            sioc      <= 1'b1;
            siod_out  <= 1'b1;
            siod_oe   <= 1'b1;
            phase     <= '0;
            bit_cnt   <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            case (phase)
              2'd0:    siod_out <= 1'b0;
              2'd2:    sioc     <= 1'b0;
              2'd3:    state    <= S_BITS;
              default: ;
            endcase
          end
        end
        S_BITS: begin
          if (tick) begin
            case (phase)
              2'd0: begin
                siod_out <= shreg[26];
                shreg    <= {shreg[25:0], 1'b1};
                // Every 9th bit is the slave's ACK slot: release the line
                siod_oe  <= !(bit_cnt == 5'd8 || bit_cnt == 5'd17 || bit_cnt == 5'd26);
              end
              2'd1: sioc <= 1'b1;
              2'd3: begin
                sioc <= 1'b0;
                if (bit_cnt == 5'd26) state   <= S_STOP;
                else                  bit_cnt <= bit_cnt + 5'd1;
              end
              default: ;
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            case (phase)
              2'd0: begin
                siod_oe  <= 1'b1;
                siod_out <= 1'b0;
              end
              2'd1: sioc     <= 1'b1;
              2'd2: siod_out <= 1'b1;
              default: begin
                siod_oe <= 1'b0;
                state   <= S_GAP;
              end
            endcase
          end
        end
        S_GAP: begin
          if (tick && phase == 2'd3) begin
            wcnt  <= '0;
            state <= rst_entry ? S_WAIT : S_NEXT;
          end
        end
        S_WAIT: begin
          if (wcnt == w_last) state <= S_NEXT;
          else                wcnt  <= wcnt + 32'd1;
        end
        S_NEXT: begin
          reg_idx <= reg_idx + 1'b1;
          state   <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config.sv
// Bench for ov7670_config: decodes the SCCB bus and scores each write against
// the expected register table for the selected colour mode.
module tb_ov7670_config;

  localparam int CLK_HZ  = 1200;
  localparam int SCCB_HZ = 100;
  localparam int Q       = CLK_HZ / (4 * SCCB_HZ);
  localparam int W       = 100;
  localparam int BUDGET  = 20000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rgbmode;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;
  logic       busy;
  logic       done;
  logic [5:0] reg_idx;

  ov7670_config #(
    .c_clk_freq  (CLK_HZ),
    .c_sccb_freq (SCCB_HZ),
    .c_rst_wait  (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rgbmode  (rgbmode),
    .sioc     (sioc),
    .siod_out (siod_out),
    .siod_oe  (siod_oe),
    .busy     (busy),
    .done     (done),
    .reg_idx  (reg_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  logic [23:0] exp_q[$];
  int          gap_q[$];
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // SCCB bus monitor
  logic        prev_sioc = 1'b1;
  logic        prev_sda  = 1'b1;
  logic        mon_sda;
  logic        in_xfer   = 1'b0;
  logic        have_stop = 1'b0;
  logic [23:0] mon_shift;
  logic [23:0] exp_word;
  int          mon_bits  = 0;
  int          ack_bad   = 0;
  int          last_rise = 0;
  int          stop_cyc  = 0;
  int          txn_cnt   = 0;
  int          edge_cnt  = 0;
  int          idle_low  = 0;

  always @(negedge clk) begin
    mon_sda = siod_oe ? siod_out : 1'b1;
    if (rst) begin
      in_xfer = 1'b0;
    end else begin
      if (sioc != prev_sioc || mon_sda != prev_sda) edge_cnt++;
      if (!in_xfer && !sioc) idle_low++;
      if (sioc && prev_sioc && prev_sda && !mon_sda) begin
        if (have_stop) gap_q.push_back(cyc - stop_cyc);
        in_xfer  = 1'b1;
        mon_bits = 0;
        ack_bad  = 0;
        mon_shift = '0;
      end else if (sioc && prev_sioc && !prev_sda && mon_sda && in_xfer) begin
        check_eq("nbits", 32'(mon_bits), 32'd27);
        check_eq("ack_release", 32'(ack_bad), 32'd0);
        check_eq("exp_avail", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          check_eq("txn", 32'(mon_shift), 32'(exp_word));
        end
        txn_cnt++;
        stop_cyc  = cyc;
        have_stop = 1'b1;
        in_xfer   = 1'b0;
      end else if (sioc && !prev_sioc && in_xfer && mon_bits < 27) begin
        if (mon_bits % 9 == 8) begin
          if (siod_oe) ack_bad++;
        end else begin
          if (!siod_oe) ack_bad++;
          mon_shift = {mon_shift[22:0], mon_sda};
        end
        if (mon_bits == 1) check_eq("sioc_period", 32'(cyc - last_rise), 32'(4 * Q));
        last_rise = cyc;
        mon_bits++;
      end
    end
    prev_sioc = sioc;
    prev_sda  = mon_sda;
  end

  // driver tasks
  task automatic push_run(input logic rgb);
    exp_q.push_back({8'h42, 8'h12, 8'h80});
    exp_q.push_back({8'h42, 8'h11, 8'h01});
    exp_q.push_back({8'h42, 8'h12, rgb ? 8'h14 : 8'h10});
    exp_q.push_back({8'h42, 8'h0C, 8'h04});
    exp_q.push_back({8'h42, 8'h3E, 8'h19});
    exp_q.push_back({8'h42, 8'h40, rgb ? 8'hD0 : 8'hC0});
    exp_q.push_back({8'h42, 8'h8C, rgb ? 8'h02 : 8'h00});
    exp_q.push_back({8'h42, 8'h3A, 8'h04});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_txns(input int target, input int bits);
    int n;
    n = 0;
    @(posedge clk);
    while (!(txn_cnt >= target && mon_bits >= bits && in_xfer) && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    check_eq("wait_txns_reached", 32'(txn_cnt >= target), 32'd1);
  endtask

  int t0;
  int e0;

  initial begin
    rst = 1'b1; start = 1'b0; rgbmode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sioc", 32'(sioc), 32'd1);
    check_eq("rst_siod_out", 32'(siod_out), 32'd1);
    check_eq("rst_siod_oe", 32'(siod_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_reg_idx", 32'(reg_idx), 32'd0);

    // Run 1: autostart after reset, RGB444
    push_run(1'b1);
    t0 = txn_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("autostart_busy", 32'(busy), 32'd1);
    wait_done("run1_done");
    check_eq("run1_busy_low", 32'(busy), 32'd0);
    check_eq("run1_reg_idx_end", 32'(reg_idx), 32'd8);
    check_eq("run1_txns", 32'(txn_cnt - t0), 32'd8);
    check_eq("run1_exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("gaps_seen", 32'(gap_q.size() >= 2), 32'd1);
    if (gap_q.size() >= 2) check_eq("soft_reset_wait", 32'(gap_q[0] - gap_q[1]), 32'(W));
    e0 = edge_cnt;
    repeat (100) @(negedge clk);
    check_eq("quiet_after_done", 32'(edge_cnt - e0), 32'd0);
    check_eq("done_held", 32'(done), 32'd1);

    // Run 2: YUV422 via start; rgbmode changes and start pulses mid-run are ignored
    push_run(1'b0);
    t0 = txn_cnt;
    @(posedge clk); #1 rgbmode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; rgbmode = 1'b1;
    @(negedge clk);
    check_eq("start_clears_done", 32'(done), 32'd0);
    check_eq("start_sets_busy", 32'(busy), 32'd1);
    wait_txns(t0 + 3, 4);
    pulse_start();
    wait_done("run2_done");
    check_eq("run2_txns", 32'(txn_cnt - t0), 32'd8);
    check_eq("run2_exp_left", 32'(exp_q.size()), 32'd0);

    // Run 3: reset in the middle of the second write's BITS phase
    push_run(1'b1);
    t0 = txn_cnt;
    pulse_start();
    wait_txns(t0 + 1, 12);
    @(negedge clk);
    check_eq("pre_rst_reg_idx", 32'(reg_idx), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_sioc", 32'(sioc), 32'd1);
    check_eq("midrst_siod_oe", 32'(siod_oe), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_reg_idx", 32'(reg_idx), 32'd0);
    exp_q.delete();
    push_run(1'b1);
    t0 = txn_cnt;
    @(posedge clk); #1 rst = 1'b0;
    wait_done("run3_done");
    check_eq("run3_txns", 32'(txn_cnt - t0), 32'd8);
    check_eq("run3_exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("sioc_idle_high", 32'(idle_low), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
